// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit path.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_DONE = 2'd1,
    NEXT      = 2'd2
  } arb_state_t;

  localparam int unsigned UART_DATA_WIDTH      = 8;
  localparam int unsigned NUM_SERIAL_BITS      = 10;
  localparam int unsigned DEFAULT_CLKS_PER_BIT = 16;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request searching upward from ptr+1.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] ptr,
  output logic [NUM_REQ-1:0]         win_onehot,
  output logic [$clog2(NUM_REQ)-1:0] win_idx
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);

  // Walk offsets from farthest to nearest so the nearest valid request wins.
  always_comb begin
    win_onehot = '0;
    win_idx    = '0;
    for (int off = NUM_REQ; off >= 1; off--) begin
      if (req[IDX_W'((32'(ptr) + 32'(off)) % NUM_REQ)]) begin
        win_idx    = IDX_W'((32'(ptr) + 32'(off)) % NUM_REQ);
        win_onehot = NUM_REQ'(1) << ((32'(ptr) + 32'(off)) % NUM_REQ);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one uart_tx serializer between NUM_REQ byte sources with round-robin
// arbitration, burst locking and a tx_done watchdog.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int unsigned NUM_REQ          = 4,
  parameter int unsigned DATA_WIDTH       = UART_DATA_WIDTH,
  parameter int unsigned NUM_CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int unsigned TIMEOUT_CLKS     = 2 * NUM_CLKS_PER_BIT * NUM_SERIAL_BITS
) (
  input  logic                          clock,
  input  logic                          rstn,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_last,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [NUM_REQ-1:0]            grant,
  output logic                          tx_start,
  output logic [DATA_WIDTH-1:0]         tx_data,
  input  logic                          tx_busy,
  input  logic                          tx_done,
  output logic                          timeout_err,
  input  logic                          err_clear
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CLKS);

  arb_state_t       state;
  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] owner;
  logic             lock;
  logic [CNT_W-1:0] cnt;

  logic [NUM_REQ-1:0]    win_oh;
  logic [IDX_W-1:0]      win_idx;
  logic [DATA_WIDTH-1:0] data_arr [NUM_REQ];

  logic                  issue_c;
  logic [IDX_W-1:0]      issue_idx_c;
  logic [NUM_REQ-1:0]    issue_oh_c;
  logic                  timeout_hit_c;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign data_arr[i] = req_data[i*DATA_WIDTH +: DATA_WIDTH];
  end

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req        (req_valid),
    .ptr        (rr_ptr),
    .win_onehot (win_oh),
    .win_idx    (win_idx)
  );

  // In NEXT the locked owner is the forced winner; grant already holds its one-hot.
  always_comb begin
    issue_c       = 1'b0;
    issue_idx_c   = win_idx;
    issue_oh_c    = win_oh;
    timeout_hit_c = 1'b0;
    if (state == IDLE) begin
      issue_c = (|req_valid) && !tx_busy;
    end else if (state == NEXT) begin
      issue_c     = req_valid[owner] && !tx_busy;
      issue_idx_c = owner;
      issue_oh_c  = grant;
    end else begin
      timeout_hit_c = !tx_done && (cnt == CNT_W'(TIMEOUT_CLKS - 1));
    end
  end

  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      state       <= IDLE;
      rr_ptr      <= IDX_W'(NUM_REQ - 1);
      owner       <= '0;
      lock        <= 1'b0;
      cnt         <= '0;
      grant       <= '0;
      req_ready   <= '0;
      tx_start    <= 1'b0;
      tx_data     <= '0;
      timeout_err <= 1'b0;
    end else begin
      tx_start  <= 1'b0;
      req_ready <= '0;

      if (timeout_hit_c)  timeout_err <= 1'b1;
      else if (err_clear) timeout_err <= 1'b0;

      unique case (state)
        IDLE, NEXT: begin
          if (issue_c) begin
            grant     <= issue_oh_c;
            req_ready <= issue_oh_c;
            tx_start  <= 1'b1;
            tx_data   <= data_arr[issue_idx_c];
            owner     <= issue_idx_c;
            lock      <= !req_last[issue_idx_c];
            cnt       <= '0;
            state     <= WAIT_DONE;
          end
        end
        WAIT_DONE: begin
          cnt <= cnt + CNT_W'(1);
          if (tx_done) begin
            if (lock) begin
              state <= NEXT;
            end else begin
              grant  <= '0;
              rr_ptr <= owner;
              state  <= IDLE;
            end
          end else if (timeout_hit_c) begin
            grant  <= '0;
            rr_ptr <= owner;
            lock   <= 1'b0;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Round-robin arbiter and sequencer that shares one uart_tx serializer between NUM_REQ byte sources, for example several message FSMs or a debug port alongside the tx control FSM. It accepts bytes on per-requester valid/ready handshakes, issues single-cycle start pulses to uart_tx, and waits for tx_done. A requester keeps its grant for a multi-byte burst until it marks the last byte. A watchdog flags a serializer that never completes.

Parameters:
NUM_REQ, 4, number of requesters (2..8).
DATA_WIDTH, 8, bits per UART data byte.
NUM_CLKS_PER_BIT, 16, uart_tx clocks per serial bit.
TIMEOUT_CLKS, 2*NUM_CLKS_PER_BIT*NUM_SERIAL_BITS (=320), watchdog limit in clocks while waiting for tx_done.

Ports:
clock  in  1  system clock; all logic on posedge.
rstn  in  1  asynchronous, active-low reset.
req_valid  in  NUM_REQ  requester i has a byte on req_data[i].
req_data  in  NUM_REQ*DATA_WIDTH  packed bytes; slice i is requester i.
req_last  in  NUM_REQ  byte on slice i ends that requester's burst.
req_ready  out  NUM_REQ  one-hot, one-cycle pulse: byte accepted.
grant  out  NUM_REQ  one-hot current owner; 0 when idle.
tx_start  out  1  one-cycle start pulse to uart_tx.
tx_data  out  DATA_WIDTH  byte to uart_tx; held until the next issue.
tx_busy  in  1  uart_tx is serializing.
tx_done  in  1  uart_tx one-cycle completion pulse.
timeout_err  out  1  sticky watchdog flag.
err_clear  in  1  clears timeout_err.

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-frame):
  - All outputs go to 0 and state goes to IDLE.
  - rr_ptr = NUM_REQ-1, so requester 0 has first priority.
  - Watchdog counter = 0; lock flag = 0.
- States: IDLE, WAIT_DONE, NEXT.
- IDLE:
  - Arbitrate only when at least one req_valid is high and tx_busy = 0.
  - Winner is the first valid index searching upward from (rr_ptr+1) mod NUM_REQ.
  - Issue on the next edge: grant <= onehot(winner), tx_data <= req_data[winner], tx_start <= 1 for one cycle, req_ready[winner] <= 1 for one cycle, lock <= !req_last[winner], counter <= 0. Go to WAIT_DONE.
  - Latency: valid sampled at edge k gives tx_start and req_ready high during cycle k+1.
- Requester rule: hold req_valid, req_data and req_last stable until req_ready is seen. The arbiter never samples valid in WAIT_DONE.
- WAIT_DONE: counter increments every cycle.
  - tx_done with lock = 1: go to NEXT; grant is held.
  - tx_done with lock = 0: grant <= 0, rr_ptr <= owner index, go to IDLE.
  - No tx_done when counter = TIMEOUT_CLKS-1: timeout_err <= 1, grant <= 0, rr_ptr <= owner, lock <= 0, go to IDLE.
  - tx_done and timeout in the same cycle: tx_done wins and no error is raised.
- NEXT: owner stays locked and other requesters are ignored.
  - If req_valid[owner] = 1 and tx_busy = 0, issue exactly as in IDLE, with the owner as the forced winner.
  - Otherwise wait indefinitely with grant held. The lock is deliberate; a burst is never interleaved.
  - Minimum gap from tx_done to the next tx_start is 2 cycles.
- Mutual exclusion: tx_start is never asserted while tx_busy = 1 or in WAIT_DONE. At most one req_ready bit is high in any cycle.
- timeout_err: set has priority over err_clear in the same cycle; otherwise err_clear clears it. It does not block arbitration.
- tx_done arriving outside WAIT_DONE is ignored.
- Widths: counter is $clog2(TIMEOUT_CLKS) bits; rr_ptr is $clog2(NUM_REQ) bits and wraps from NUM_REQ-1 to 0.

Decomposition:
- uart_pkg:
  - arb_state_t enum {IDLE, WAIT_DONE, NEXT}.
  - UART_DATA_WIDTH = 8, NUM_SERIAL_BITS = 10.
  - Default NUM_CLKS_PER_BIT = 16.
- Sub-module rr_arbiter: purely combinational. Inputs are the request vector and rr_ptr; outputs are the one-hot winner and its index. It is reusable by the RX-side scheduler.
- FSM, watchdog and output registers live in uart_tx_arbiter.

Test Plan:
1. Single byte: req_valid = 0001, data A5, last = 1 → tx_start for 1 cycle with tx_data = A5. req_ready = 0001 pulses in the same cycle. grant = 0001 until tx_done, then 0000.
2. Fairness: req0 and req2 continuously valid with last = 1 and a uart_tx model in the loop → grant sequence 0001, 0100, 0001, 0100, …; req0 is never served twice in a row.
3. Burst lock: req1 sends A5, A8, AB, AE with last on AE while req3 is valid → four tx_starts with bytes in that order, all with grant = 0010, then req3 is granted.
4. Watchdog: tx_done withheld after issue → timeout_err = 1 exactly 320 cycles after tx_start, grant = 0. Then err_clear → 0. Also: tx_done on cycle 319 gives no error.
5. Busy gate: tx_busy = 1 with req0 valid → no tx_start. Drop tx_busy at edge k → tx_start in cycle k+1.
6. Reset mid-burst: rstn low during WAIT_DONE → grant, tx_start and req_ready go to 0 immediately. After release with all requesters valid, requester 0 is served first.
